// File: rtl/vchess_pkg.sv
// vchess_pkg: shared definitions for the board display path.
//   - piece type encodings (EMPTY..ILLEGAL) and the colour bit index
//   - streamer FSM state enum
//   - piece_to_ascii(): one square code -> printable ASCII character
// A square is PIECE_W bits: [3] colour (1 = black), [2:0] piece type.
package vchess_pkg;

  localparam int PIECE_W    = 4;
  localparam int COLOUR_BIT = 3;

  localparam logic [2:0] EMPTY   = 3'd0;
  localparam logic [2:0] PAWN    = 3'd1;
  localparam logic [2:0] KNIGHT  = 3'd2;
  localparam logic [2:0] BISHOP  = 3'd3;
  localparam logic [2:0] ROOK    = 3'd4;
  localparam logic [2:0] QUEEN   = 3'd5;
  localparam logic [2:0] KING    = 3'd6;
  localparam logic [2:0] ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQUARE,
    ST_EOL,
    ST_SIDE,
    ST_SIDE_EOL
  } state_t;

  // Uppercase for white, lowercase for black. Empty and illegal squares
  // print the same glyph for both colours.
  function automatic logic [7:0] piece_to_ascii(input logic [PIECE_W-1:0] piece);
    logic [7:0] c;
    case (piece[2:0])
      EMPTY:   c = 8'h2E; // '.'
      PAWN:    c = 8'h50; // 'P'
      KNIGHT:  c = 8'h4E; // 'N'
      BISHOP:  c = 8'h42; // 'B'
      ROOK:    c = 8'h52; // 'R'
      QUEEN:   c = 8'h51; // 'Q'
      KING:    c = 8'h4B; // 'K'
      default: c = 8'h3F; // '?'
    endcase
    // ASCII lowercase is uppercase with bit 5 set.
    if (piece[COLOUR_BIT] && (piece[2:0] != EMPTY) && (piece[2:0] != ILLEGAL))
      c = c | 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/board_streamer_piece_ascii.sv
// piece_ascii: combinational wrapper around vchess_pkg::piece_to_ascii so the
// mapping can be exercised on its own.
// Ports:
//   piece  in  PIECE_W  square code ([3] colour, [2:0] type)
//   ascii  out 8        printable character for that square
module piece_ascii
  import vchess_pkg::*;
(
  input  logic [PIECE_W-1:0] piece,
  output logic [7:0]         ascii
);

  assign ascii = piece_to_ascii(piece);

endmodule

// File: rtl/board_streamer.sv
// board_streamer: snapshots a packed board on a valid/ready handshake and
// streams it as ASCII, one character per accepted output beat. Rank RANKS-1
// is printed first, files 0..FILES-1 left to right, '\n' after every rank.
//
// Optional feature (macro BOARD_STREAMER_SIDE_EN): after the last rank a
// side-to-move line "W\n" or "B\n" is appended and out_last moves to that
// final '\n'. Without the macro, out_last marks the last rank's '\n' and
// white_to_move is captured but has no effect on the output.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset; aborts a frame
//   board          in   BOARD_WIDTH packed board, square(r,f) at
//                       [(r*FILES+f)*PIECE_WIDTH +: PIECE_WIDTH]
//   board_valid    in   board offered
//   board_ready    out  idle; board captured when board_valid is high
//   white_to_move  in   side to move, captured with board
//   out_data       out  8-bit ASCII character
//   out_valid      out  out_data valid
//   out_ready      in   sink accepts out_data
//   out_last       out  final character of the frame
//   busy           out  frame in progress
module board_streamer
  import vchess_pkg::*;
#(
  parameter int PIECE_WIDTH = 4,
  parameter int FILES       = 8,
  parameter int RANKS       = 8,
  parameter int ROW_WIDTH   = 32,
  parameter int BOARD_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_WIDTH-1:0] board,
  input  logic                   board_valid,
  output logic                   board_ready,
  input  logic                   white_to_move,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  localparam int FILE_W = (FILES > 1) ? $clog2(FILES) : 1;
  localparam int RANK_W = (RANKS > 1) ? $clog2(RANKS) : 1;

  if (ROW_WIDTH != FILES * PIECE_WIDTH) begin : g_row_chk
    $error("board_streamer: ROW_WIDTH must equal FILES*PIECE_WIDTH");
  end
  if (BOARD_WIDTH != RANKS * ROW_WIDTH) begin : g_board_chk
    $error("board_streamer: BOARD_WIDTH must equal RANKS*ROW_WIDTH");
  end
  if (PIECE_WIDTH != PIECE_W) begin : g_piece_chk
    $error("board_streamer: PIECE_WIDTH must match vchess_pkg::PIECE_W");
  end

  state_t                   state, state_n;
  logic [FILE_W-1:0]        file_q, file_n;
  logic [RANK_W-1:0]        rank_q, rank_n;
  logic [BOARD_WIDTH-1:0]   snap;
  logic                     wtm;
  logic                     capture, accept;
  logic [BOARD_WIDTH-1:0]   src;
  logic                     src_wtm;
  logic [PIECE_WIDTH-1:0]   sq_arr [RANKS][FILES];
  logic [PIECE_WIDTH-1:0]   sq_n;
  logic [7:0]               sq_char;
  logic [7:0]               char_n;
  logic                     last_n;

  assign board_ready = (state == ST_IDLE);
  assign busy        = ~board_ready;
  assign out_valid   = busy;
  assign capture     = board_ready & board_valid;
  assign accept      = out_valid & out_ready;

  // The output register is loaded with the character of the *next* state,
  // so on the capture cycle the first square must come straight from the
  // input bus rather than the snapshot that is being written.
  assign src     = capture ? board : snap;
  assign src_wtm = capture ? white_to_move : wtm;

  for (genvar r = 0; r < RANKS; r++) begin : g_rank
    for (genvar f = 0; f < FILES; f++) begin : g_file
      assign sq_arr[r][f] = src[(r*FILES + f)*PIECE_WIDTH +: PIECE_WIDTH];
    end
  end

  assign sq_n = sq_arr[rank_n][file_n];

  piece_ascii u_piece_ascii (
    .piece (sq_n),
    .ascii (sq_char)
  );

  always_comb begin
    state_n = state;
    file_n  = file_q;
    rank_n  = rank_q;
    case (state)
      ST_IDLE: begin
        if (capture) begin
          state_n = ST_SQUARE;
          file_n  = '0;
          rank_n  = RANK_W'(RANKS - 1);
        end
      end
      ST_SQUARE: begin
        if (accept) begin
          if (file_q == FILE_W'(FILES - 1)) state_n = ST_EOL;
          else                              file_n  = file_q + FILE_W'(1);
        end
      end
      ST_EOL: begin
        if (accept) begin
          if (rank_q == '0) begin
`ifdef BOARD_STREAMER_SIDE_EN
            state_n = ST_SIDE;
`else
            state_n = ST_IDLE;
`endif
          end else begin
            state_n = ST_SQUARE;
            rank_n  = rank_q - RANK_W'(1);
            file_n  = '0;
          end
        end
      end
      ST_SIDE: begin
        if (accept) state_n = ST_SIDE_EOL;
      end
      ST_SIDE_EOL: begin
        if (accept) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    char_n = 8'h00;
    case (state_n)
      ST_SQUARE:             char_n = sq_char;
      ST_EOL, ST_SIDE_EOL:   char_n = 8'h0A;
      ST_SIDE:               char_n = src_wtm ? 8'h57 : 8'h42; // 'W' / 'B'
      default:               char_n = 8'h00;
    endcase
  end

`ifdef BOARD_STREAMER_SIDE_EN
  assign last_n = (state_n == ST_SIDE_EOL);
`else
  assign last_n = (state_n == ST_EOL) && (rank_n == '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      file_q   <= '0;
      rank_q   <= '0;
      out_data <= 8'h00;
      out_last <= 1'b0;
    end else begin
      state    <= state_n;
      file_q   <= file_n;
      rank_q   <= rank_n;
      out_data <= char_n;
      out_last <= last_n;
    end
  end

  // Snapshot is pure data: only loaded on capture, never reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      snap <= board;
      wtm  <= white_to_move;
    end
  end

endmodule
